cmsdk_ahb_flash_rd_ctrl: RTL and testbench
==========================================

# cmsdk_ahb_flash_rd_ctrl

AHB-Lite read-only slave that initiates accesses to the 32-bit behavioural flash (cmsdk_flash_rom32) on the code bus. It converts AHB read transfers into word addresses, holds each address stable for the flash's WS wait states, and stalls HREADYOUT until flash data is valid. A one-word line buffer gives zero-wait repeat reads. Writes return a two-cycle ERROR response.

## Interface
- AW, 16, flash byte-address width; must equal the flash model's AW
- WS, 0, flash wait states; must equal the flash model's WS; range 0..15
- clk  in  1  clock
- rst  in  1  reset; **synchronous, active-high**
- hsel  in  1  slave select
- haddr  in  AW  byte address; [1:0] ignored
- htrans  in  2  AHB transfer type
- hsize  in  3  ignored; a full word is always returned
- hwrite  in  1  write indicator
- hready  in  1  bus ready; address phase accepted when high
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  32  read data
- flash_addr  out  AW-2  word address to flash, registered
- flash_rdata  in  32  flash data; all ones when the flash is not ready

## Operation
- Transfer valid when hsel & hready & htrans[1].
- A valid write goes to ERR1.
- A valid read on word haddr[AW-1:2] is a **hit** if buf_valid and the word equals buf_addr.
  - Hit: data phase completes in 1 cycle, hrdata = buf_data, flash_addr unchanged.
  - Miss: flash_addr <= haddr[AW-1:2] and state goes to WAIT, wait_cnt = 0.
- FSM states are IDLE, WAIT, ERR1, ERR2.
  - **IDLE**: hreadyout=1, hresp=0, hrdata=buf_data.
  - **WAIT**: hreadyout = (wait_cnt == WS). hrdata = flash_rdata when hreadyout=1, else buf_data. wait_cnt increments each cycle, saturating at WS.
    - On the completing cycle, buf_data <= flash_rdata, buf_addr <= flash_addr and buf_valid <= 1.
    - The next state comes from the address phase sampled on that same cycle (pipelined back-to-back).
  - **ERR1**: hreadyout=0, hresp=1; always goes to ERR2.
  - **ERR2**: hreadyout=1, hresp=1; the next state comes from the address phase sampled on this cycle.
- htrans IDLE/BUSY or hsel=0 with hready=1 goes to IDLE and gives a zero-wait OKAY.
- flash_addr is held constant throughout WAIT. The controller never samples flash_rdata before the flash's wait count reaches WS, so the all-ones not-ready value is never returned.
- Reset values:
  - Outputs: hreadyout=1, hresp=0, flash_addr=0, hrdata=0.
  - Internal: buf_valid=0, buf_addr=0, buf_data=0, wait_cnt=0, state IDLE.
- Reset asserted mid-WAIT or mid-ERR aborts the access. All reset values apply from the first cycle after the rst edge, and no ERROR is issued.

## Timing
- Miss read latency is WS+1 data-phase cycles (WS stall cycles). With WS=0 the read is zero-wait and hit and miss latency are equal.
- Data-phase cycle k has flash_addr stable for k+1 cycles. The flash is ready at k = WS, which is the completing cycle.
- Hit latency is 1 cycle regardless of WS.
- Write latency is 2 cycles (ERR1, ERR2). The first cycle has hreadyout=0, as AHB-Lite requires.
- Back-to-back misses to different words take (WS+1) cycles each, with no bubble between them.
- Simultaneous cases:
  - Completing a miss while the next address phase hits the word just fetched counts as a hit; buf_valid/buf_addr are compared after that cycle's update.
  - A write accepted during the completing cycle of a read goes to ERR1 on the next cycle.

## Structure
- Package cmsdk_flash_pkg holds:
  - the state enum (IDLE/WAIT/ERR1/ERR2);
  - HTRANS constants (IDLE=2'b00, BUSY=2'b01, NSEQ=2'b10, SEQ=2'b11);
  - HRESP constants (OKAY=0, ERROR=1).
- wait_cnt is $clog2(WS+1) bits wide, with a minimum of 1 bit.
- Sub-module cmsdk_flash_line_buf holds buf_valid/buf_addr/buf_data, the hit compare and the load port.

## Test plan
- WS=2, flash word 0x4 = 0x12345678, NSEQ read at haddr=0x0010 after reset -> hreadyout low for 2 cycles, high on the 3rd with hrdata=0x12345678 and hresp=0. flash_addr=0x4 is held all 3 cycles.
- Same setup, immediate second read at 0x0012 (same word) -> completes in 1 cycle with hrdata=0x12345678 and flash_addr unchanged.
- WS=2, back-to-back reads 0x0000 then 0x0004 (words 0xAAAA0000, 0xBBBB1111) -> 3 cycles each, correct data, and no all-ones value ever returned.
- Write NSEQ to 0x0020 -> cycle 1: hreadyout=0, hresp=1; cycle 2: hreadyout=1, hresp=1. A following read completes normally.
- rst=1 during the 2nd WAIT cycle of a WS=3 miss -> next cycle hreadyout=1, hresp=0, hrdata=0. A following read of the same address is a miss taking 4 cycles.
- WS=0, htrans IDLE/BUSY and hsel=0 cycles interleaved with reads -> every cycle hreadyout=1 with OKAY, and each read completes with zero wait.

Source files
------------

// File: rtl/cmsdk_flash_pkg.sv
// rtl/cmsdk_flash_pkg.sv - shared types and constants for the AHB flash read controller
package cmsdk_flash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Width of a counter that must hold 0..ws, never narrower than one bit
  function automatic int cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/cmsdk_flash_line_buf.sv
// rtl/cmsdk_flash_line_buf.sv - one-word read line buffer with hit compare and load port
module cmsdk_flash_line_buf #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-3:0] lookup_addr,
  output logic          hit,
  input  logic          load,
  input  logic [AW-3:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   buf_data
);

  logic          buf_valid;
  logic [AW-3:0] buf_addr;

  // Capture the word fetched from flash on the completing cycle of a miss
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_addr  <= load_addr;
      buf_data  <= load_data;
    end
  end

  // Compare against the post-load contents so a lookup during a load sees the new word
  always_comb begin
    hit = 1'b0;
    if (load) hit = (lookup_addr == load_addr);
    else      hit = buf_valid && (lookup_addr == buf_addr);
  end

endmodule

// File: rtl/cmsdk_ahb_flash_rd_ctrl.sv
// rtl/cmsdk_ahb_flash_rd_ctrl.sv - AHB-Lite read-only slave in front of a wait-stated 32-bit flash
module cmsdk_ahb_flash_rd_ctrl
  import cmsdk_flash_pkg::*;
#(
  parameter int AW = 16,
  parameter int WS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic          hwrite,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [31:0]   hrdata,
  output logic [AW-3:0] flash_addr,
  input  logic [31:0]   flash_rdata
);

  localparam int            CW     = cnt_width(WS);
  localparam logic [CW-1:0] WS_CNT = CW'(WS);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [AW-3:0] word;
  logic          valid;
  logic          complete;
  logic          accept;
  logic          hit;
  logic [31:0]   buf_data;
  logic          unused_bits;

  assign word        = haddr[AW-1:2];
  assign valid       = hsel & hready & htrans[1];
  assign complete    = (state == ST_WAIT) && (wait_cnt == WS_CNT);
  // A new address phase is only taken where the current data phase ends
  assign accept      = (state == ST_IDLE) || (state == ST_ERR2) || complete;
  assign unused_bits = ^{hsize, htrans[0], haddr[1:0]};

  // Flash data goes straight to the bus on the completing cycle, else the buffered word
  assign hrdata = complete ? flash_rdata : buf_data;

  cmsdk_flash_line_buf #(.AW(AW)) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(word),
    .hit        (hit),
    .load       (complete),
    .load_addr  (flash_addr),
    .load_data  (flash_rdata),
    .buf_data   (buf_data)
  );

  // Transfer FSM with registered bus responses and flash address
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      flash_addr <= '0;
      hreadyout  <= 1'b1;
      hresp      <= HRESP_OKAY;
    end else if (accept) begin
      wait_cnt <= '0;
      if (!valid) begin
        state     <= ST_IDLE;
        hreadyout <= 1'b1;
        hresp     <= HRESP_OKAY;
      end else if (hwrite) begin
        state     <= ST_ERR1;
        hreadyout <= 1'b0;
        hresp     <= HRESP_ERROR;
      end else if (hit) begin
        state     <= ST_IDLE;
        hreadyout <= 1'b1;
        hresp     <= HRESP_OKAY;
      end else begin
        state      <= ST_WAIT;
        flash_addr <= word;
        hreadyout  <= (WS_CNT == '0);
        hresp      <= HRESP_OKAY;
      end
    end else if (state == ST_WAIT) begin
      if (wait_cnt != WS_CNT) wait_cnt <= wait_cnt + ONE;
      hreadyout <= ((wait_cnt + ONE) == WS_CNT);
    end else if (state == ST_ERR1) begin
      state     <= ST_ERR2;
      hreadyout <= 1'b1;
      hresp     <= HRESP_ERROR;
    end
  end

endmodule

// File: tb/tb_cmsdk_ahb_flash_rd_ctrl.sv
// tb/tb_cmsdk_ahb_flash_rd_ctrl.sv - directed vector bench for the AHB flash read controller
module tb_cmsdk_ahb_flash_rd_ctrl;
  import cmsdk_flash_pkg::*;

  typedef struct {
    int          di;
    logic        rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] haddr;
    logic        chk;
    logic        e_rdy;
    logic        e_resp;
    logic        chk_d;
    logic [31:0] e_data;
    logic        chk_fa;
    logic [13:0] e_fa;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [15:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [2:0]  hsize = 3'b010;
  logic        hwrite = 1'b0;

  logic        rdy_v [3];
  logic        rsp_v [3];
  logic [31:0] rd_v  [3];
  logic [13:0] fa_v  [3];
  logic [31:0] fd_v  [3];

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [13:0] w);
    case (w)
      14'd0:   return 32'hAAAA0000;
      14'd1:   return 32'hBBBB1111;
      14'd4:   return 32'h12345678;
      default: return {16'hC0DE, 2'b00, w};
    endcase
  endfunction

  // Three controllers (WS = 2, 3, 0), each with its own flash model and ready loop
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WSG = (g == 0) ? 2 : (g == 1) ? 3 : 0;
    logic [13:0] last;
    int          cnt;
    int          stable;

    cmsdk_ahb_flash_rd_ctrl #(.AW(16), .WS(WSG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .hsel       (hsel),
      .haddr      (haddr),
      .htrans     (htrans),
      .hsize      (hsize),
      .hwrite     (hwrite),
      .hready     (rdy_v[g]),
      .hreadyout  (rdy_v[g]),
      .hresp      (rsp_v[g]),
      .hrdata     (rd_v[g]),
      .flash_addr (fa_v[g]),
      .flash_rdata(fd_v[g])
    );

    initial begin
      last = '1;
      cnt  = 0;
    end
    assign stable  = (fa_v[g] == last) ? cnt + 1 : 1;
    assign fd_v[g] = (stable >= WSG + 1) ? mem_word(fa_v[g]) : 32'hFFFFFFFF;
    always @(posedge clk) begin
      if (fa_v[g] == last) begin
        if (cnt < 1000) cnt <= cnt + 1;
      end else begin
        last <= fa_v[g];
        cnt  <= 1;
      end
    end
  end

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic add(input int di, input logic r, input logic s, input logic [1:0] t, input logic w,
                     input logic [15:0] a, input logic c, input logic er, input logic ep,
                     input logic cd, input logic [31:0] ed, input logic cf, input logic [13:0] ef);
    vec_t v;
    v.di = di; v.rst = r; v.hsel = s; v.htrans = t; v.hwrite = w; v.haddr = a;
    v.chk = c; v.e_rdy = er; v.e_resp = ep; v.chk_d = cd; v.e_data = ed;
    v.chk_fa = cf; v.e_fa = ef;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    rst = v.rst; hsel = v.hsel; htrans = v.htrans; hwrite = v.hwrite; haddr = v.haddr;
    @(negedge clk);
    if (v.chk) begin
      chk("hreadyout", id, 32'(rdy_v[v.di]), 32'(v.e_rdy));
      chk("hresp", id, 32'(rsp_v[v.di]), 32'(v.e_resp));
      if (v.chk_d)  chk("hrdata", id, rd_v[v.di], v.e_data);
      if (v.chk_fa) chk("flash_addr", id, 32'(fa_v[v.di]), 32'(v.e_fa));
      chk("not_ready_data", id, 32'(rdy_v[v.di] && (rd_v[v.di] == 32'hFFFFFFFF)), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0;
  endtask

  // Miss then pipelined same-word hit, cycle-counted with a bounded wait
  task automatic measure(input int di, input int exp_cycles, input int id);
    int n;
    rst = 1'b1; bus_idle();
    @(posedge clk); #1;
    rst = 1'b0; hsel = 1'b1; htrans = HTRANS_NSEQ; haddr = 16'h0140;
    @(posedge clk); #1;
    bus_idle();
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rdy_v[di]) break;
      @(posedge clk); #1;
    end
    chk("miss_latency", id, 32'(n), 32'(exp_cycles));
    chk("miss_data", id, rd_v[di], 32'hC0DE0050);
    hsel = 1'b1; htrans = HTRANS_SEQ; haddr = 16'h0141;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    chk("hit_ready", id, 32'(rdy_v[di]), 32'd1);
    chk("hit_data", id, rd_v[di], 32'hC0DE0050);
    chk("hit_flash_addr", id, 32'(fa_v[di]), 32'h50);
    @(posedge clk); #1;
  endtask

  initial begin
    // WS=2: cold miss, same-word hit, back-to-back misses, write error, pipelined hit
    add(0,1, 0,0,0,16'h0000, 0, 0,0,0,0,0,0);
    add(0,0, 1,2,0,16'h0010, 1, 1,0,1,32'h0,1,14'h0);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h4);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h4);
    add(0,0, 1,2,0,16'h0012, 1, 1,0,1,32'h12345678,1,14'h4);
    add(0,0, 1,2,0,16'h0000, 1, 1,0,1,32'h12345678,1,14'h4);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h0);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h0);
    add(0,0, 1,2,0,16'h0004, 1, 1,0,1,32'hAAAA0000,1,14'h0);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h1);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h1);
    add(0,0, 1,2,1,16'h0020, 1, 1,0,1,32'hBBBB1111,1,14'h1);
    add(0,0, 0,0,0,16'h0000, 1, 0,1,0,32'h0,1,14'h1);
    add(0,0, 1,2,0,16'h0010, 1, 1,1,0,32'h0,1,14'h1);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h4);
    add(0,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h4);
    add(0,0, 1,2,0,16'h0013, 1, 1,0,1,32'h12345678,1,14'h4);
    add(0,0, 0,0,0,16'h0000, 1, 1,0,1,32'h12345678,1,14'h4);
    add(0,0, 0,0,0,16'h0000, 1, 1,0,1,32'h12345678,1,14'h4);
    // WS=3: reset during the second wait cycle aborts, re-read is a full miss
    add(1,1, 0,0,0,16'h0000, 0, 0,0,0,0,0,0);
    add(1,0, 1,2,0,16'h0040, 1, 1,0,1,32'h0,1,14'h0);
    add(1,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h10);
    add(1,1, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h10);
    add(1,0, 1,2,0,16'h0040, 1, 1,0,1,32'h0,1,14'h0);
    add(1,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h10);
    add(1,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h10);
    add(1,0, 0,0,0,16'h0000, 1, 0,0,0,32'h0,1,14'h10);
    add(1,0, 0,0,0,16'h0000, 1, 1,0,1,32'hC0DE0010,1,14'h10);
    add(1,0, 0,0,0,16'h0000, 1, 1,0,1,32'hC0DE0010,1,14'h10);
    // WS=0: zero-wait reads interleaved with BUSY, IDLE and deselected cycles
    add(2,1, 0,0,0,16'h0000, 0, 0,0,0,0,0,0);
    add(2,0, 1,2,0,16'h0008, 1, 1,0,1,32'h0,1,14'h0);
    add(2,0, 1,1,0,16'h0030, 1, 1,0,1,32'hC0DE0002,1,14'h2);
    add(2,0, 0,2,0,16'h000C, 1, 1,0,1,32'hC0DE0002,1,14'h2);
    add(2,0, 1,2,0,16'h000C, 1, 1,0,1,32'hC0DE0002,1,14'h2);
    add(2,0, 1,0,0,16'h0030, 1, 1,0,1,32'hC0DE0003,1,14'h3);
    add(2,0, 1,2,0,16'h0008, 1, 1,0,1,32'hC0DE0003,1,14'h3);
    add(2,0, 1,2,0,16'h000A, 1, 1,0,1,32'hC0DE0002,1,14'h2);
    add(2,0, 1,2,1,16'h0008, 1, 1,0,1,32'hC0DE0002,1,14'h2);
    add(2,0, 0,0,0,16'h0000, 1, 0,1,0,32'h0,1,14'h2);
    add(2,0, 0,0,0,16'h0000, 1, 1,1,0,32'h0,1,14'h2);
    add(2,0, 0,0,0,16'h0000, 1, 1,0,1,32'hC0DE0002,1,14'h2);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    measure(0, 3, 100);
    measure(1, 4, 101);
    measure(2, 1, 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
